// File: rtl/mem_stage_sb.sv
// RV32 MEM stage with a FIFO store buffer in front of a single data-memory port.
// Loads forward from the youngest buffered store or issue a read that pre-empts draining.
module mem_stage_sb #(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4,
  parameter int RF_AW    = 5,
  parameter int CNT_W    = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic                      flush_i,
  input  logic                      valid_i,
  input  logic                      we_i,
  input  logic [XLEN-1:0]           addr_i,
  input  logic [XLEN-1:0]           wdata_i,
  input  logic [XLEN-1:0]           alu_i,
  input  logic [XLEN-1:0]           pc4_i,
  input  logic [XLEN-1:0]           inst_i,
  input  logic [1:0]                wbsel_i,
  input  logic                      regwen_i,
  input  logic [RF_AW-1:0]          rd_i,
  output logic [XLEN-1:0]           alu_o,
  output logic [XLEN-1:0]           pc4_o,
  output logic [XLEN-1:0]           mem_o,
  output logic [XLEN-1:0]           inst_o,
  output logic [1:0]                wbsel_o,
  output logic                      regwen_o,
  output logic [RF_AW-1:0]          rd_o,
  output logic                      stall_o,
  output logic                      mem_req_valid_o,
  output logic                      mem_req_we_o,
  output logic [XLEN-1:0]           mem_req_addr_o,
  output logic [XLEN-1:0]           mem_req_wdata_o,
  input  logic                      mem_ready_i,
  input  logic [XLEN-1:0]           mem_rdata_i,
  output logic [$clog2(SB_DEPTH):0] sb_count_o,
  output logic [CNT_W-1:0]          no_acc_o,
  output logic [CNT_W-1:0]          no_fwd_o,
  output logic [CNT_W-1:0]          no_full_o
);

  localparam int PW  = $clog2(SB_DEPTH);
  localparam int CW  = PW + 1;
  localparam int WAW = XLEN - 2;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RD = 2'd1, ST_WR = 2'd2} state_e;

  typedef struct packed {
    logic [XLEN-1:0]  alu;
    logic [XLEN-1:0]  pc4;
    logic [XLEN-1:0]  mem;
    logic [XLEN-1:0]  inst;
    logic [1:0]       wbsel;
    logic             regwen;
    logic [RF_AW-1:0] rd;
  } wb_t;

  logic [WAW-1:0]  sb_addr_q [SB_DEPTH];
  logic [XLEN-1:0] sb_data_q [SB_DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, count_d;
  state_e          state_q, state_d;
  logic            load_done_q, load_done_d;
  logic [XLEN-1:0] ld_data_q, ld_data_d;
  wb_t             wb_q, wb_d;
  logic [CNT_W-1:0] no_acc_q, no_fwd_q, no_full_q;

  logic            full_s, push_s, pop_s, hit_s, load_miss_s, stall_s, upd_s;
  logic [XLEN-1:0] fwd_data_s, mem_w_s;
  logic            unused_addr_s;

  assign unused_addr_s = ^addr_i[1:0];

  assign full_s      = (count_q == CW'(SB_DEPTH));
  assign push_s      = valid_i & we_i & enable_i & ~full_s;
  assign pop_s       = (state_q == ST_WR) & mem_ready_i;
  assign count_d     = count_q + CW'(push_s) - CW'(pop_s);
  assign load_miss_s = valid_i & ~we_i & ~hit_s & ~load_done_q;
  assign stall_s     = (valid_i & we_i & full_s) |
                       (load_miss_s & ~((state_q == ST_RD) & mem_ready_i));
  assign mem_w_s     = load_done_q ? ld_data_q : (hit_s ? fwd_data_s : mem_rdata_i);
  assign upd_s       = enable_i & ~stall_s & valid_i;

  // Forwarding search from oldest to youngest so the youngest match wins.
  always_comb begin
    hit_s      = 1'b0;
    fwd_data_s = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if ((CW'(k) < count_q) && (sb_addr_q[head_q + PW'(k)] == addr_i[XLEN-1:2])) begin
        hit_s      = 1'b1;
        fwd_data_s = sb_data_q[head_q + PW'(k)];
      end else begin
        hit_s      = hit_s;
        fwd_data_s = fwd_data_s;
      end
    end
  end

  // Port FSM next state and memory request outputs.
  always_comb begin
    state_d         = state_q;
    mem_req_valid_o = 1'b0;
    mem_req_we_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_wdata_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (load_miss_s) begin
          state_d = ST_RD;
        end else if (count_q != '0) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {addr_i[XLEN-1:2], 2'b00};
        state_d         = mem_ready_i ? ST_IDLE : ST_RD;
      end
      ST_WR: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        mem_req_addr_o  = {sb_addr_q[head_q], 2'b00};
        mem_req_wdata_o = sb_data_q[head_q];
        state_d         = mem_ready_i ? ST_IDLE : ST_WR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A read that finishes while the pipe is frozen is parked until enable returns.
  always_comb begin
    load_done_d = load_done_q;
    ld_data_d   = ld_data_q;
    if ((state_q == ST_RD) && mem_ready_i && !enable_i) begin
      load_done_d = 1'b1;
      ld_data_d   = mem_rdata_i;
    end else if (enable_i) begin
      load_done_d = 1'b0;
      ld_data_d   = '0;
    end else begin
      load_done_d = load_done_q;
      ld_data_d   = ld_data_q;
    end
  end

  // MEM->WB register next value.
  always_comb begin
    wb_d = wb_q;
    if (enable_i && flush_i) begin
      wb_d = '0;
    end else if (enable_i && !stall_s) begin
      wb_d = '{alu: alu_i, pc4: pc4_i, mem: mem_w_s, inst: inst_i,
               wbsel: wbsel_i, regwen: regwen_i, rd: rd_i};
    end else begin
      wb_d = wb_q;
    end
  end

  // Buffer storage; validity is tracked by pointers and count only.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      sb_addr_q[tail_q] <= addr_i[XLEN-1:2];
      sb_data_q[tail_q] <= wdata_i;
    end
  end

  // Control state, pointers and WB registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      load_done_q <= 1'b0;
      ld_data_q   <= '0;
      wb_q        <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_q + PW'(pop_s);
      tail_q      <= tail_q + PW'(push_s);
      count_q     <= count_d;
      load_done_q <= load_done_d;
      ld_data_q   <= ld_data_d;
      wb_q        <= wb_d;
    end
  end

  // Performance counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      no_acc_q  <= '0;
      no_fwd_q  <= '0;
      no_full_q <= '0;
    end else begin
      no_acc_q  <= no_acc_q + CNT_W'(upd_s);
      no_fwd_q  <= no_fwd_q + CNT_W'(upd_s & ~we_i & hit_s);
      no_full_q <= no_full_q + CNT_W'(valid_i & we_i & full_s);
    end
  end

  assign stall_o    = stall_s;
  assign sb_count_o = count_q;
  assign alu_o      = wb_q.alu;
  assign pc4_o      = wb_q.pc4;
  assign mem_o      = wb_q.mem;
  assign inst_o     = wb_q.inst;
  assign wbsel_o    = wb_q.wbsel;
  assign regwen_o   = wb_q.regwen;
  assign rd_o       = wb_q.rd;
  assign no_acc_o   = no_acc_q;
  assign no_fwd_o   = no_fwd_q;
  assign no_full_o  = no_full_q;

endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed bench for mem_stage_sb with a small latency-programmable memory responder.
module tb_mem_stage_sb;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        enable_i, flush_i, valid_i, we_i;
  logic [31:0] addr_i, wdata_i, alu_i, pc4_i, inst_i;
  logic [1:0]  wbsel_i;
  logic        regwen_i;
  logic [4:0]  rd_i;
  logic [31:0] alu_o, pc4_o, mem_o, inst_o;
  logic [1:0]  wbsel_o;
  logic        regwen_o;
  logic [4:0]  rd_o;
  logic        stall_o, mem_req_valid_o, mem_req_we_o;
  logic [31:0] mem_req_addr_o, mem_req_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic [2:0]  sb_count_o;
  logic [31:0] no_acc_o, no_fwd_o, no_full_o;

  int          lat, pulse_req, pulse_done, wait_cnt, wcnt, rcnt;
  bit          hold;
  logic [31:0] wlog_addr [32];
  logic [31:0] wlog_data [32];
  int          n_pass = 0, n_total = 0;

  mem_stage_sb #(.XLEN(32), .SB_DEPTH(4), .RF_AW(5), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .flush_i(flush_i),
    .valid_i(valid_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .alu_i(alu_i), .pc4_i(pc4_i), .inst_i(inst_i), .wbsel_i(wbsel_i),
    .regwen_i(regwen_i), .rd_i(rd_i), .alu_o(alu_o), .pc4_o(pc4_o),
    .mem_o(mem_o), .inst_o(inst_o), .wbsel_o(wbsel_o), .regwen_o(regwen_o),
    .rd_o(rd_o), .stall_o(stall_o), .mem_req_valid_o(mem_req_valid_o),
    .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i), .sb_count_o(sb_count_o), .no_acc_o(no_acc_o),
    .no_fwd_o(no_fwd_o), .no_full_o(no_full_o)
  );

  initial forever #5 clk_i = ~clk_i;

  // Memory responder: acts 3 time units after each rising edge.
  initial begin
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'hDEADBEEF;
    pulse_done  = 0;
    wait_cnt    = 0;
    wcnt        = 0;
    rcnt        = 0;
    forever begin
      @(posedge clk_i);
      #3;
      mem_ready_i = 1'b0;
      mem_rdata_i = 32'hDEADBEEF;
      if (mem_req_valid_o) begin
        if ((hold && (pulse_req > pulse_done)) || (!hold && (wait_cnt == lat))) begin
          mem_ready_i = 1'b1;
          if (hold) pulse_done++;
          wait_cnt = 0;
          if (mem_req_we_o) begin
            if (wcnt < 32) begin
              wlog_addr[wcnt] = mem_req_addr_o;
              wlog_data[wcnt] = mem_req_wdata_o;
            end
            wcnt++;
          end else begin
            mem_rdata_i = mem_req_addr_o ^ 32'hC0DE0000;
            rcnt++;
          end
        end else if (hold) begin
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic put(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    valid_i = v;
    we_i    = w;
    addr_i  = a;
    wdata_i = d;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb_count_o != 3'd0; i++) next();
    chk(tag, 32'(sb_count_o), 32'd0);
  endtask

  initial begin
    int  n_st;
    bit  done;
    logic we_seen;
    hold = 1'b0; lat = 2; pulse_req = 0;
    rst_ni = 1'b0; enable_i = 1'b1; flush_i = 1'b0;
    put(1'b0, 1'b0, 32'h0, 32'h0);
    alu_i = 32'hA1; pc4_i = 32'h4; inst_i = 32'h13; wbsel_i = 2'd1; regwen_i = 1'b1; rd_i = 5'd3;
    next(); next();
    chk("rst_alu", alu_o, 32'h0);
    chk("rst_mem", mem_o, 32'h0);
    chk("rst_cnt", 32'(sb_count_o), 32'h0);
    chk("rst_req_valid", 32'(mem_req_valid_o), 32'h0);
    chk("rst_req_addr", mem_req_addr_o, 32'h0);
    chk("rst_no_acc", no_acc_o, 32'h0);
    chk("rst_no_full", no_full_o, 32'h0);
    rst_ni = 1'b1;
    next();

    // Three stores drain in FIFO order without stalling.
    put(1'b1, 1'b1, 32'h100, 32'h11111111); settle(); chk("st0_stall", 32'(stall_o), 32'h0); next();
    put(1'b1, 1'b1, 32'h104, 32'h22222222); settle(); chk("st1_stall", 32'(stall_o), 32'h0); next();
    put(1'b1, 1'b1, 32'h108, 32'h33333333); settle(); chk("st2_stall", 32'(stall_o), 32'h0); next();
    put(1'b0, 1'b0, 32'h0, 32'h0);
    chk("sb_peak", 32'(sb_count_o), 32'd3);
    drain("drain1");
    chk("wcnt1", 32'(wcnt), 32'd3);
    chk("w0_addr", wlog_addr[0], 32'h100);
    chk("w1_data", wlog_data[1], 32'h22222222);
    chk("w2_addr", wlog_addr[2], 32'h108);
    chk("no_acc1", no_acc_o, 32'd3);

    // Youngest matching store forwards to a load with a byte offset.
    hold = 1'b1;
    put(1'b1, 1'b1, 32'h100, 32'h0000AAAA); next();
    put(1'b1, 1'b1, 32'h100, 32'h0000BBBB); next();
    put(1'b1, 1'b0, 32'h102, 32'h0); alu_i = 32'h12345678; rd_i = 5'd7;
    settle(); chk("fwd_stall", 32'(stall_o), 32'h0);
    next();
    put(1'b0, 1'b0, 32'h0, 32'h0);
    chk("fwd_mem", mem_o, 32'h0000BBBB);
    chk("fwd_cnt", no_fwd_o, 32'd1);
    chk("fwd_alu", alu_o, 32'h12345678);
    chk("fwd_rd", 32'(rd_o), 32'd7);
    chk("fwd_no_write", 32'(wcnt), 32'd3);
    hold = 1'b0; lat = 0;
    drain("drain2");
    chk("wcnt2", 32'(wcnt), 32'd5);
    chk("w3_data", wlog_data[3], 32'h0000AAAA);
    chk("w4_data", wlog_data[4], 32'h0000BBBB);

    // Load miss with three wait cycles stalls for four cycles.
    lat = 3; n_st = 0; done = 1'b0; we_seen = 1'b0;
    put(1'b1, 1'b0, 32'h200, 32'h0);
    for (int i = 0; i < 20 && !done; i++) begin
      settle();
      if (mem_req_valid_o) we_seen = we_seen | mem_req_we_o;
      if (stall_o) begin
        n_st++;
        next();
      end else begin
        done = 1'b1;
      end
    end
    chk("rd_done", 32'(done), 32'd1);
    next();
    put(1'b0, 1'b0, 32'h0, 32'h0);
    chk("rd_stall_cycles", 32'(n_st), 32'd4);
    chk("rd_req_we", 32'(we_seen), 32'd0);
    chk("rd_mem", mem_o, 32'hC0DE0200);
    chk("rd_count", 32'(rcnt), 32'd1);

    // Full buffer stalls a fifth store until one entry drains.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, 1'b1, 32'h300 + 32'(4 * i), 32'h40 + 32'(i));
      next();
    end
    chk("full_cnt", 32'(sb_count_o), 32'd4);
    put(1'b1, 1'b1, 32'h310, 32'h55);
    settle(); chk("full_stall0", 32'(stall_o), 32'd1); next();
    chk("no_full1", no_full_o, 32'd1);
    settle(); next();
    chk("no_full2", no_full_o, 32'd2);
    pulse_req++;
    settle(); chk("full_stall2", 32'(stall_o), 32'd1); next();
    chk("pop_cnt", 32'(sb_count_o), 32'd3);
    chk("no_full3", no_full_o, 32'd3);
    settle(); chk("accept_stall", 32'(stall_o), 32'd0); next();
    put(1'b0, 1'b0, 32'h0, 32'h0);
    chk("refill_cnt", 32'(sb_count_o), 32'd4);
    hold = 1'b0; lat = 1;
    drain("drain4");
    chk("wcnt4", 32'(wcnt), 32'd10);
    chk("w5_addr", wlog_addr[5], 32'h300);
    chk("w9_addr", wlog_addr[9], 32'h310);
    chk("w9_data", wlog_data[9], 32'h55);

    // Read finishing while enable is low is held and delivered later.
    put(1'b1, 1'b0, 32'h400, 32'h0);
    settle(); chk("ld_stall0", 32'(stall_o), 32'd1); next();
    enable_i = 1'b0;
    settle(); next();
    settle(); chk("ld_done_stall", 32'(stall_o), 32'd0); next();
    settle(); chk("ld_no_reissue", 32'(mem_req_valid_o), 32'd0); next();
    enable_i = 1'b1;
    next();
    put(1'b0, 1'b0, 32'h0, 32'h0);
    chk("ld_done_mem", mem_o, 32'hC0DE0400);
    chk("ld_one_read", 32'(rcnt), 32'd2);

    // Flush zeroes WB registers but buffered stores still commit.
    hold = 1'b1; alu_i = 32'hA5A50001; inst_i = 32'h00000033;
    put(1'b1, 1'b1, 32'h500, 32'h61); next();
    put(1'b1, 1'b1, 32'h504, 32'h62); next();
    put(1'b0, 1'b0, 32'h0, 32'h0); flush_i = 1'b1; alu_i = 32'h77;
    next();
    flush_i = 1'b0;
    chk("flush_alu", alu_o, 32'h0);
    chk("flush_inst", inst_o, 32'h0);
    chk("flush_mem", mem_o, 32'h0);
    chk("flush_cnt", 32'(sb_count_o), 32'd2);
    hold = 1'b0;
    drain("drain6");
    chk("wcnt6", 32'(wcnt), 32'd12);
    chk("w10_addr", wlog_addr[10], 32'h500);
    chk("w11_data", wlog_data[11], 32'h62);
    chk("no_acc_end", no_acc_o, 32'd15);
    chk("no_fwd_end", no_fwd_o, 32'd1);
    chk("no_full_end", no_full_o, 32'd3);

    // Asynchronous reset drops a buffered store.
    hold = 1'b1;
    put(1'b1, 1'b1, 32'h600, 32'h99); next();
    put(1'b0, 1'b0, 32'h0, 32'h0);
    chk("pre_rst_cnt", 32'(sb_count_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("arst_cnt", 32'(sb_count_o), 32'd0);
    chk("arst_req", 32'(mem_req_valid_o), 32'd0);
    chk("arst_acc", no_acc_o, 32'd0);
    next();
    rst_ni = 1'b1; hold = 1'b0;
    repeat (5) next();
    chk("arst_dropped", 32'(wcnt), 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
